cla_pipe: RTL and testbench

CLA_PIPE -- requirements
Module: cla_pipe

---
 rtl/cla_pipe.sv | 141 ++++++++++++++
 tb/tb_cla_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined adder/subtractor built from chained 4-bit carry-lookahead blocks.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe #(
    parameter int WIDTH       = 32,
    parameter int BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CLA_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             co,
    output logic [WIDTH-1:0] s
);
    localparam int SW   = 4 * BLK_PER_STG;
    localparam int NSTG = WIDTH / SW;

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // the whole pipe advances together on en, so in_ready mirrors en.
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign cin0     = sub | ci;

    // Returns {carry_out, sum[3:0]} of one 4-bit lookahead block.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    genvar k;
    generate
        for (k = 0; k < NSTG; k++) begin : g_stg
            localparam int LO = k * SW;
            localparam int RW = WIDTH - LO;

            // ra_i/rb_i hold the slices not yet added; the low SW bits are this stage's slice.
            logic [RW-1:0]    ra_i;
            logic [RW-1:0]    rb_i;
            logic [LO+SW-1:0] s_n;
            logic [LO+SW-1:0] s_q;
            logic [SW-1:0]    sum;
            logic             c_i;
            logic             v_i;
            logic             c_o;
            logic             c_q;
            logic             v_q;

            if (k == 0) begin : g_src
                assign ra_i = a;
                assign rb_i = b_eff;
                assign c_i  = cin0;
                assign v_i  = in_valid;
                assign s_n  = sum;
            end else begin : g_src
                assign ra_i = g_stg[k-1].g_ops.a_q;
                assign rb_i = g_stg[k-1].g_ops.b_q;
                assign c_i  = g_stg[k-1].c_q;
                assign v_i  = g_stg[k-1].v_q;
                assign s_n  = {sum, g_stg[k-1].s_q};
            end

            always_comb begin : p_add
                logic       c;
                logic [4:0] r;
                c   = c_i;
                r   = '0;
                sum = '0;
                for (int j = 0; j < BLK_PER_STG; j++) begin
                    r             = cla4(ra_i[4*j +: 4], rb_i[4*j +: 4], c);
                    sum[4*j +: 4] = r[3:0];
                    c             = r[4];
                end
                c_o = c;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (en) begin
                    v_q <= v_i;
                    c_q <= c_o;
                    s_q <= s_n;
                end
            end

            // Operand skew registers; contents of bubble slots are don't-care.
            if (k < NSTG - 1) begin : g_ops
                logic [RW-SW-1:0] a_q;
                logic [RW-SW-1:0] b_q;
                always_ff @(posedge clk) begin
                    if (en) begin
                        a_q <= ra_i[RW-1:SW];
                        b_q <= rb_i[RW-1:SW];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[NSTG-1].v_q;
    assign s         = g_stg[NSTG-1].s_q;
    assign co        = g_stg[NSTG-1].c_q;

`ifdef CLA_PIPE_OVF_EN
    // Carry into the MSB equals a' ^ b' ^ sum at that bit, so ovf = that ^ carry-out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (en) begin
            ovf <= g_stg[NSTG-1].ra_i[SW-1] ^ g_stg[NSTG-1].rb_i[SW-1]
                 ^ g_stg[NSTG-1].sum[SW-1] ^ g_stg[NSTG-1].c_o;
        end
    end
`endif
endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe (WIDTH=32, BLK_PER_STG=2): vector table,
// scoreboard queue, stall, back-pressure and mid-operation reset sequences.
module tb_cla_pipe;
    localparam int WIDTH = 32;
    localparam int EW    = WIDTH + 2;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             ci = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic             co;
    logic [WIDTH-1:0] s;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    cla_pipe #(.WIDTH(WIDTH), .BLK_PER_STG(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CLA_PIPE_OVF_EN
        .ovf       (ovf),
`endif
        .co        (co),
        .s         (s)
    );

    // Clock
    always #5 clk = ~clk;

    int               checks = 0;
    int               failures = 0;
    int               pops = 0;
    int               cyc = 0;
    bit               bp_en = 1'b0;
    logic [EW-1:0]    exp_q[$];
    int               pop_cyc[$];
    logic [EW-1:0]    mon_e;
    vec_t             tbl[12];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: {ovf, co, s} from plain 33-bit arithmetic.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic mci, input logic msub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        logic             v;
        bb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mci)};
        v  = (ma[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
        return {v, t};
    endfunction

    // Driver: present operands, transfer on the first edge with in_ready=1.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tci, input logic tsub, input logic [EW-1:0] e);
        int n;
        n = 0;
        a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b expected=1", in_ready);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, 1);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: compare each result on the cycle it is consumed.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL out_unexpected s=%h co=%b expected=no_result", s, co);
            end else begin
                mon_e = exp_q.pop_front();
                pops++;
                pop_cyc.push_back(cyc);
                check("out_s", s, mon_e[WIDTH-1:0]);
                check("out_co", co, mon_e[WIDTH]);
`ifdef CLA_PIPE_OVF_EN
                check("out_ovf", ovf, mon_e[WIDTH+1]);
`endif
            end
        end
    end

    initial begin
        int n;
        int gaps;
        int p0;
        int seen;
        logic [WIDTH-1:0] hold;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rci;
        logic             rsub;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0};
        tbl[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        tbl[3]  = '{32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345679, 1'b0, 1'b0};
        tbl[4]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[6]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[7]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[10] = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0};
        tbl[11] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};

        // Reset state, with out_ready low so in_ready depends on out_valid=0
        reset_n = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef CLA_PIPE_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple and latency
        send(tbl[0].a, tbl[0].b, tbl[0].ci, tbl[0].sub, {tbl[0].ovf, tbl[0].co, tbl[0].s});
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check("ripple_latency", n, 4);
        drain();

        // Table vectors back to back; results must come out on consecutive cycles
        pop_cyc.delete();
        for (int i = 1; i < 12; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, {tbl[i].ovf, tbl[i].co, tbl[i].s});
        end
        drain();
        gaps = 0;
        for (int i = 1; i < pop_cyc.size(); i++) begin
            if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
        end
        check("table_pops", pop_cyc.size(), 11);
        check("table_gaps", gaps, 0);

        // Stall: results held while out_ready=0, then each released once
        out_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom(); rb = $urandom(); rci = 1'($urandom_range(0, 1)); rsub = 1'(i == 1);
            send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
        end
        wait_out_valid("stall_first_valid");
        hold = s;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_s_held", s, hold);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("stall_pops", pops - p0, 3);

        // Random operands with bubbles and random back-pressure
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0: begin ra = 32'hFFFFFFFF; rb = $urandom(); end
                1: begin ra = 32'h7FFFFFFF; rb = $urandom_range(0, 3); end
                default: begin ra = $urandom(); rb = $urandom(); end
            endcase
            rci = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with transactions in flight: discarded, nothing emerges afterwards
        out_ready = 1'b0;
        send(32'h11111111, 32'h22222222, 1'b0, 1'b0, model(32'h11111111, 32'h22222222, 1'b0, 1'b0));
        send(32'h33333333, 32'h00000001, 1'b0, 1'b1, model(32'h33333333, 32'h00000001, 1'b0, 1'b1));
        wait_out_valid("midrst_first_valid");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_co", co, 0);
        check("midrst_in_ready", in_ready, 1);
`ifdef CLA_PIPE_OVF_EN
        check("midrst_ovf", ovf, 0);
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_silent", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
